// File: rtl/mem_lane_pkg.sv
// Shared definitions for the MEM-stage byte-lane access unit:
// lane mask codes, FSM state encoding and mask normalisation.
package mem_lane_pkg;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Any mask code other than byte or half is treated as a full word.
  function automatic logic [3:0] norm_mask(input logic [3:0] m);
    logic [3:0] r;
    case (m)
      MASK_BYTE: r = MASK_BYTE;
      MASK_HALF: r = MASK_HALF;
      default:   r = MASK_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_extract.sv
// Load-side lane extractor: moves the addressed byte/half down to bit 0
// and sign- or zero-extends it; full words pass straight through.
module byte_lane_extract
  import mem_lane_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_mask,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  // Shift the selected lane to bit 0, then extend according to size and signedness.
  always_comb begin
    w_shifted = i_rdata >> {i_offset, 3'b000};
    case (i_mask)
      MASK_BYTE: o_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      MASK_HALF: o_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_byte_lane_ctrl.sv
// MEM-stage data-memory access unit driving a word-wide synchronous RAM.
// Partial stores use read-modify-write; loads extract and extend the lane.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word
// accesses complete immediately with rsp_err=1 instead of being aligned).
module mem_byte_lane_ctrl
  import mem_lane_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_mask,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e r_state;
  state_e w_next;

  // Captured request
  logic        r_write;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic [3:0]  r_mask;
  logic [15:0] r_wdata;

  // Registered outputs
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  // Next values for the registered outputs
  logic              w_rsp_valid_d;
  logic [31:0]       w_rsp_rdata_d;
  logic              w_rsp_err_d;
  logic              w_mem_en_d;
  logic              w_mem_we_d;
  logic [MEM_AW-1:0] w_mem_addr_d;
  logic [31:0]       w_mem_wdata_d;

  logic        w_accept;
  logic [3:0]  w_req_mask;
  logic [1:0]  w_req_off;
  logic        w_trap;
  logic [31:0] w_merged;
  logic [31:0] w_load_data;
  logic        w_unused_addr;

  assign w_accept      = req_valid & (r_state == ST_IDLE);
  assign w_req_mask    = norm_mask(req_mask);
  assign w_unused_addr = ^req_addr[31:MEM_AW+2];

  // Lane offset of the incoming request, forced to the access size's alignment.
  always_comb begin
    case (w_req_mask)
      MASK_BYTE: w_req_off = req_addr[1:0];
      MASK_HALF: w_req_off = {req_addr[1], 1'b0};
      default:   w_req_off = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned half/word requests are trapped rather than silently aligned.
  always_comb begin
    case (w_req_mask)
      MASK_HALF: w_trap = req_addr[0];
      MASK_WORD: w_trap = |req_addr[1:0];
      default:   w_trap = 1'b0;
    endcase
  end
`else
  assign w_trap = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: loads and partial stores read first; word stores write directly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_trap) begin
            w_next = ST_RESP;
          end else if (req_write && (w_req_mask == MASK_WORD)) begin
            w_next = ST_WRITE;
          end else begin
            w_next = ST_READ;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_READ:  w_next = ST_MERGE;
      ST_MERGE: begin
        if (r_write) begin
          w_next = ST_WRITE;
        end else begin
          w_next = ST_RESP;
        end
      end
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Capture the request at the accept edge; held until the access completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_mask     <= 4'b0000;
      r_wdata    <= 16'h0000;
    end else if (w_accept) begin
      r_write    <= req_write;
      r_unsigned <= req_unsigned;
      r_off      <= w_req_off;
      r_mask     <= w_req_mask;
      r_wdata    <= req_wdata[15:0];
    end
  end

  // Read-modify-write merge: replace only the addressed lane of the read word.
  always_comb begin
    w_merged = mem_rdata;
    case (r_mask)
      MASK_BYTE: w_merged[{r_off, 3'b000} +: 8]      = r_wdata[7:0];
      MASK_HALF: w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
      default:   w_merged = mem_rdata;
    endcase
  end

  byte_lane_extract u_extract (
    .i_rdata    (mem_rdata),
    .i_offset   (r_off),
    .i_mask     (r_mask),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  // FSM outputs: next values of every registered output, derived from the transition.
  always_comb begin
    w_mem_en_d    = (w_next == ST_READ) || (w_next == ST_WRITE);
    w_mem_we_d    = (w_next == ST_WRITE);
    w_rsp_valid_d = (w_next == ST_RESP);
    w_rsp_err_d   = w_accept & w_trap;
    if ((r_state == ST_MERGE) && !r_write) begin
      w_rsp_rdata_d = w_load_data;
    end else begin
      w_rsp_rdata_d = 32'h0000_0000;
    end
    if (w_accept) begin
      w_mem_addr_d = req_addr[MEM_AW+1:2];
    end else begin
      w_mem_addr_d = r_mem_addr;
    end
    if (w_accept && req_write && !w_trap && (w_req_mask == MASK_WORD)) begin
      w_mem_wdata_d = req_wdata;
    end else if ((r_state == ST_MERGE) && r_write) begin
      w_mem_wdata_d = w_merged;
    end else begin
      w_mem_wdata_d = r_mem_wdata;
    end
  end

  // Output registers; reset abandons any in-flight access with the write strobe low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {MEM_AW{1'b0}};
      r_mem_wdata <= 32'h0000_0000;
    end else begin
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
      r_mem_en    <= w_mem_en_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_byte_lane_ctrl.sv
// Bench for mem_byte_lane_ctrl: bench-side synchronous RAM, a behavioural
// access model with a per-cycle compare process, and directed vectors
// with literal expectations. Honours MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_byte_lane_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic [3:0]    req_mask = 4'h0;
  logic          req_unsigned = 1'b0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  mem_byte_lane_ctrl #(.MEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM, plus a bench-only preload port.
  logic [31:0]   ram [0:1023];
  logic [31:0]   ram_q = 32'h0;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_idx = '0;
  logic [31:0]   pre_val = 32'h0;
  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_val;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else ram_q <= ram[mem_addr];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [31:0] model_mem [0:1023];
  bit          chk_on = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  int          lat = 0;
  int          exp_idx = 0;
  bit          exp_store = 1'b0;
  bit          exp_trap = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  // Model of one access: latency, response data/error and memory effect.
  task automatic model_accept(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] mask, input bit uns);
    int n, off;
    longint w, v, d;
    n = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 : 4;
    off = int'(addr[1:0]);
    exp_idx = int'(addr[11:2]);
    exp_trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (off % n != 0) exp_trap = 1'b1;
`endif
    off = off - (off % n);
    exp_store = wr;
    exp_rdata = 32'h0;
    if (exp_trap) lat = 1;
    else if (!wr) lat = 3;
    else if (n == 4) lat = 2;
    else lat = 4;
    if (!exp_trap) begin
      w = {32'h0, model_mem[exp_idx]};
      d = {32'h0, data};
      if (wr) begin
        for (int i = 0; i < n; i++) begin
          w = w - (((w >> (8 * (off + i))) % 256) << (8 * (off + i)))
                + (((d >> (8 * i)) % 256) << (8 * (off + i)));
        end
        model_mem[exp_idx] = w[31:0];
      end else begin
        v = (w >> (8 * off)) % (64'sd1 << (8 * n));
        if (!uns && n < 4 && v >= (64'sd1 << (8 * n - 1)))
          v = v + (64'sd1 << 32) - (64'sd1 << (8 * n));
        exp_rdata = v[31:0];
      end
    end
  endtask

  // Per-cycle compare of handshake, RAM strobes and response against the model.
  always @(negedge clk) begin
    bit exp_v;
    if (!chk_on || !rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) cnt++;
      exp_v = pend && (cnt == lat);
      chk("req_ready", 32'(req_ready), 32'(!pend));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("mem_we", 32'(mem_we), 32'(pend && exp_store && !exp_trap && cnt == lat - 1));
      chk("mem_en", 32'(mem_en),
          32'(pend && !exp_trap && (cnt == 1 || (exp_store && cnt == lat - 1))));
      if (exp_v) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_trap));
        if (!exp_trap) chk("ram_word", ram[exp_idx], model_mem[exp_idx]);
        last_rdata = rsp_rdata;
        last_err = rsp_err;
        pend = 1'b0;
      end
      if (req_valid && !pend) begin
        model_accept(req_write, req_addr, req_wdata, req_mask, req_unsigned);
        pend = 1'b1;
        cnt = 0;
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    pre_idx = AW'(idx);
    pre_val = val;
    pre_en = 1'b1;
    model_mem[idx] = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issue one request once the DUT is ready, then wait (bounded) for its response.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input bit uns);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("ready_timeout", 32'(k < 50), 32'd1);
    req_write = wr; req_addr = addr; req_wdata = data; req_mask = mask; req_unsigned = uns;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (pend && k < 20) begin @(posedge clk); #1; k++; end
    chk("rsp_timeout", 32'(pend), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    preload(0, 32'hCAFE_F00D);
    preload(6, 32'h5566_7788);

    // Reset while a byte store is in MERGE: the edge that would enter WRITE resets instead.
    req_write = 1'b1; req_addr = 32'h18; req_wdata = 32'h99; req_mask = 4'b0001;
    req_valid = 1'b1;
    @(posedge clk); #1;            // accepted, now READ
    req_valid = 1'b0;
    @(posedge clk); #1;            // MERGE
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);                // after reset edge
    chk("rstmid_mem_we", 32'(mem_we), 32'd0);
    chk("rstmid_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_outs", {mem_wdata[15:0], 6'(mem_addr), 7'd0, rsp_err, rsp_valid, mem_we}, 32'h0);
    chk("post_rst_rdata", rsp_rdata, 32'h0);
    chk("post_rst_ram6", ram[6], 32'h5566_7788);
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (4) @(posedge clk);     // idle: checker expects no memory activity
    #1;

    // Word store
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    chk("sw_ram4", ram[4], 32'hDEAD_BEEF);
    // Byte store via read-modify-write
    preload(4, 32'h1122_3344);
    access(1'b1, 32'h11, 32'h0000_00AA, 4'b0001, 1'b0);
    chk("sb_ram4", ram[4], 32'h1122_AA44);
    // Byte loads, signed and unsigned
    preload(4, 32'h80FF_0000);
    access(1'b0, 32'h13, 32'h0, 4'b0001, 1'b0);
    chk("lb_13", last_rdata, 32'hFFFF_FF80);
    access(1'b0, 32'h13, 32'h0, 4'b0001, 1'b1);
    chk("lbu_13", last_rdata, 32'h0000_0080);
    access(1'b0, 32'h12, 32'h0, 4'b0001, 1'b0);
    chk("lb_12", last_rdata, 32'hFFFF_FFFF);
    // Half loads
    preload(4, 32'h8001_0000);
    access(1'b0, 32'h12, 32'h0, 4'b0011, 1'b0);
    chk("lh_12", last_rdata, 32'hFFFF_8001);
    access(1'b0, 32'h12, 32'h0, 4'b0011, 1'b1);
    chk("lhu_12", last_rdata, 32'h0000_8001);
    access(1'b0, 32'h10, 32'h0, 4'b0011, 1'b0);
    chk("lh_10", last_rdata, 32'h0000_0000);
    // Half store into the upper lane, byte store into lane 3
    preload(5, 32'hAABB_CCDD);
    access(1'b1, 32'h16, 32'h1234_BEEF, 4'b0011, 1'b0);
    chk("sh_ram5", ram[5], 32'hBEEF_CCDD);
    access(1'b1, 32'h17, 32'h0000_0042, 4'b0001, 1'b0);
    chk("sb3_ram5", ram[5], 32'h42EF_CCDD);
    // Undefined mask code behaves as a word access
    access(1'b1, 32'h20, 32'h0BAD_CAFE, 4'b0110, 1'b0);
    chk("sw_oddmask_ram8", ram[8], 32'h0BAD_CAFE);
    access(1'b0, 32'h20, 32'h0, 4'b0101, 1'b0);
    chk("lw_oddmask", last_rdata, 32'h0BAD_CAFE);
    // Misaligned word load and half load
    access(1'b0, 32'h02, 32'h0, 4'b1111, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_02_err", 32'(last_err), 32'd1);
    chk("lw_02_rdata", last_rdata, 32'h0);
`else
    chk("lw_02_err", 32'(last_err), 32'd0);
    chk("lw_02_rdata", last_rdata, 32'hCAFE_F00D);
`endif
    access(1'b0, 32'h15, 32'h0, 4'b0011, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lhu_15_rdata", last_rdata, 32'h0);
`else
    chk("lhu_15_rdata", last_rdata, 32'h0000_CCDD);
`endif
    // Misaligned half store
    access(1'b1, 32'h13, 32'h0000_7777, 4'b0011, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("sh_13_ram4", ram[4], 32'h8001_0000);
`else
    chk("sh_13_ram4", ram[4], 32'h7777_0000);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
